// File: rtl/gray_frame_if.sv
// Handshake and datapath bundle between the frame sequencer,
// the image memories, the gray converter and the task FSM.
interface gray_frame_if #(
  parameter int ROW_W = 6,
  parameter int COL_W = 6
);
  logic             start;
  logic             hold;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [23:0]      in_pix;
  logic [23:0]      gray_in_pix;
  logic [23:0]      gray_out_pix;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic             out_we;
  logic [23:0]      out_pix;
  logic             busy;
  logic             done;

  modport master (
    output start, hold, in_pix, gray_out_pix,
    input  row, col, gray_in_pix,
    input  out_row, out_col, out_we, out_pix,
    input  busy, done
  );

  modport slave (
    input  start, hold, in_pix, gray_out_pix,
    output row, col, gray_in_pix,
    output out_row, out_col, out_we, out_pix,
    output busy, done
  );
endinterface

// File: rtl/gray_frame_ctrl.sv
// Raster-order frame sequencer for the grayscale datapath:
// reads each pixel, feeds the converter, writes the result back.
module gray_frame_ctrl #(
  parameter int IMG_ROWS = 64,
  parameter int IMG_COLS = 64,
  parameter int ROW_W    = 6,
  parameter int COL_W    = 6
) (
  input logic        clk,
  input logic        rst,
  gray_frame_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COLS - 1);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             drain_q, drain_d;

  logic             v1_q, v2_q;
  logic [ROW_W-1:0] r1_q, r2_q;
  logic [COL_W-1:0] c1_q, c2_q;
  logic [23:0]      pix_q;

  logic last_row;
  logic last_col;

  assign last_row = (row_q == ROW_LAST);
  assign last_col = (col_q == COL_LAST);

  // control state and address counters; hold freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= 1'b0;
    end else if (!bus.hold) begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
    end
  end

  // next state and raster address walk
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = READ;
          row_d   = '0;
          col_d   = '0;
        end
      end
      READ: begin
        if (last_row && last_col) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else if (last_col) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q) state_d = DONE;
        else         drain_d = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // two-stage pipeline: memory latency, then converter register
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      r1_q  <= '0;
      c1_q  <= '0;
      r2_q  <= '0;
      c2_q  <= '0;
      pix_q <= '0;
    end else if (!bus.hold) begin
      v1_q <= (state_q == READ);
      r1_q <= row_q;
      c1_q <= col_q;
      v2_q <= v1_q;
      r2_q <= r1_q;
      c2_q <= c1_q;
      if (v1_q) pix_q <= bus.in_pix;
    end
  end

  assign bus.row         = row_q;
  assign bus.col         = col_q;
  assign bus.gray_in_pix = pix_q;
  assign bus.out_row     = r2_q;
  assign bus.out_col     = c2_q;
  assign bus.out_we      = v2_q && !bus.hold;
  assign bus.out_pix     = bus.gray_out_pix;
  assign bus.busy        = (state_q == READ) ||
                           (state_q == DRAIN);
  assign bus.done        = (state_q == DONE) && !bus.hold;

endmodule
